// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the MIPS pipeline register bank: NOP encoding and ID control-bus layout.
package pipe_stage_regs_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int CTRL_REG_WRITE   = 7;
  localparam int CTRL_MEM_TO_REG  = 6;
  localparam int CTRL_MEM_WRITE   = 5;
  localparam int CTRL_BRANCH      = 4;
  localparam int CTRL_ALU_SRC     = 3;
  localparam int CTRL_REG_DST     = 2;
  localparam int CTRL_ALU_CTRL_HI = 1;
  localparam int CTRL_ALU_CTRL_LO = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_ctrl;
  } ctrl_t;

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Bundle of hazard commands, fetch/decode inputs and IF/ID, ID/EX, counter outputs.
interface pipe_stage_regs_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  logic              stall_F, stall_D, flush_D, flush_E;
  logic [DATA_W-1:0] pc_next_F, instr_F, pc_plus4_F;
  logic [CTRL_W-1:0] ctrl_D;
  logic [DATA_W-1:0] rd1_D, rd2_D, sign_imm_D;
  logic [REG_AW-1:0] rs_D, rt_D, rd_D;

  logic [DATA_W-1:0] pc_F, instr_D, pc_plus4_D;
  logic              valid_D;
  logic [CTRL_W-1:0] ctrl_E;
  logic [DATA_W-1:0] rd1_E, rd2_E, sign_imm_E;
  logic [REG_AW-1:0] rs_E, rt_E, rd_E;
  logic              valid_E;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output stall_F, stall_D, flush_D, flush_E, pc_next_F, instr_F, pc_plus4_F,
           ctrl_D, rd1_D, rd2_D, sign_imm_D, rs_D, rt_D, rd_D,
    input  pc_F, instr_D, pc_plus4_D, valid_D, ctrl_E, rd1_E, rd2_E, sign_imm_E,
           rs_E, rt_E, rd_E, valid_E, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall_F, stall_D, flush_D, flush_E, pc_next_F, instr_F, pc_plus4_F,
           ctrl_D, rd1_D, rd2_D, sign_imm_D, rs_D, rt_D, rd_D,
    output pc_F, instr_D, pc_plus4_D, valid_D, ctrl_E, rd1_E, rd2_E, sign_imm_E,
           rs_E, rt_E, rd_E, valid_E, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline register: synchronous active-low reset, clear, enable (rst > clr > en).
module pipe_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] val_d, val_q;

  always_comb begin
    val_d = val_q;
    if (clr)     val_d = '0;
    else if (en) val_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) val_q <= RST_VAL;
    else        val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX registers acting on hazard-unit stall/flush commands, with saturating event counters.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                REG_AW   = 5,
  parameter int                CTRL_W   = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_stage_regs_if.slave bus
);

  localparam int IFID_W = 2*DATA_W + 1;
  localparam int IDEX_W = CTRL_W + 3*DATA_W + 3*REG_AW + 1;
  localparam logic [IFID_W-1:0] IFID_RST = {DATA_W'(NOP_INSTR), {DATA_W{1'b0}}, 1'b0};

  logic [IFID_W-1:0] ifid_in, ifid_out;
  logic [IDEX_W-1:0] idex_in, idex_out;

  // ---- PC (fetch) ----
  pipe_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(!bus.stall_F),
    .d(bus.pc_next_F), .q(bus.pc_F)
  );

  // ---- IF/ID: a clear loads NOP, which encodes as all-zero ----
  assign ifid_in = {bus.instr_F, bus.pc_plus4_F, 1'b1};

  pipe_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush_D), .en(!bus.stall_D),
    .d(ifid_in), .q(ifid_out)
  );

  assign bus.instr_D    = ifid_out[IFID_W-1 -: DATA_W];
  assign bus.pc_plus4_D = ifid_out[DATA_W -: DATA_W];
  assign bus.valid_D    = ifid_out[0];

  // ---- ID/EX: never stalls, flush inserts a bubble ----
  assign idex_in = {bus.ctrl_D, bus.rd1_D, bus.rd2_D, bus.sign_imm_D,
                    bus.rs_D, bus.rt_D, bus.rd_D, ifid_out[0]};

  pipe_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush_E), .en(1'b1),
    .d(idex_in), .q(idex_out)
  );

  assign {bus.ctrl_E, bus.rd1_E, bus.rd2_E, bus.sign_imm_E,
          bus.rs_E, bus.rt_E, bus.rd_E, bus.valid_E} = idex_out;

  // ---- event counters ----
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.stall_D)               stall_cnt_d = sat_inc(stall_cnt_q);
    if (bus.flush_D | bus.flush_E) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, free flow, load-use, flush/stall collision, saturation, reset mid-stall.
module tb_pipe_stage_regs;
  import pipe_stage_regs_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic        stall_F, stall_D, flush_D, flush_E;
  logic [31:0] pc_next_F, instr_F, pc_plus4_F;
  logic [7:0]  ctrl_D;
  logic [31:0] rd1_D, rd2_D, sign_imm_D;
  logic [4:0]  rs_D, rt_D, rd_D;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_regs_if #(.CNT_W(16)) bus ();
  pipe_stage_regs_if #(.CNT_W(4))  bus_s ();

  assign bus.stall_F = stall_F;       assign bus_s.stall_F = stall_F;
  assign bus.stall_D = stall_D;       assign bus_s.stall_D = stall_D;
  assign bus.flush_D = flush_D;       assign bus_s.flush_D = flush_D;
  assign bus.flush_E = flush_E;       assign bus_s.flush_E = flush_E;
  assign bus.pc_next_F = pc_next_F;   assign bus_s.pc_next_F = pc_next_F;
  assign bus.instr_F = instr_F;       assign bus_s.instr_F = instr_F;
  assign bus.pc_plus4_F = pc_plus4_F; assign bus_s.pc_plus4_F = pc_plus4_F;
  assign bus.ctrl_D = ctrl_D;         assign bus_s.ctrl_D = ctrl_D;
  assign bus.rd1_D = rd1_D;           assign bus_s.rd1_D = rd1_D;
  assign bus.rd2_D = rd2_D;           assign bus_s.rd2_D = rd2_D;
  assign bus.sign_imm_D = sign_imm_D; assign bus_s.sign_imm_D = sign_imm_D;
  assign bus.rs_D = rs_D;             assign bus_s.rs_D = rs_D;
  assign bus.rt_D = rt_D;             assign bus_s.rt_D = rt_D;
  assign bus.rd_D = rd_D;             assign bus_s.rd_D = rd_D;

  pipe_stage_regs #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  pipe_stage_regs #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  logic [31:0] pc_tab    [3] = '{32'd4, 32'd8, 32'd12};
  logic [31:0] instr_tab [3] = '{32'h2001_0005, 32'h8C22_0004, 32'h0043_1820};
  logic [31:0] p4_tab    [3] = '{32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
  logic [7:0]  ctrl_tab  [3] = '{8'h8A, 8'hC9, 8'h84};
  logic [31:0] rd1_tab   [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
  logic [31:0] rd2_tab   [3] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
  logic [31:0] imm_tab   [3] = '{32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF0};
  logic [4:0]  rs_tab    [3] = '{5'd0, 5'd1, 5'd2};
  logic [4:0]  rt_tab    [3] = '{5'd1, 5'd2, 5'd3};
  logic [4:0]  rd_tab    [3] = '{5'd7, 5'd8, 5'd3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0; flush_E = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_D = 1'b1; flush_E = 1'b1; stall_F = 1'b1; flush_D = 1'b0;
    pc_next_F = 32'hDEAD_BEEF; instr_F = 32'h1234_5678; pc_plus4_F = 32'h5555_5555;
    ctrl_D = 8'hFF; rd1_D = 32'h7777_7777; rd2_D = 32'h6666_6666; sign_imm_D = 32'h1;
    rs_D = 5'd9; rt_D = 5'd10; rd_D = 5'd11;
    step(); step();
    n_cmp++; if (bus.pc_F !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", bus.pc_F, RST_PC); end
    n_cmp++; if (bus.instr_D !== 32'h0) begin n_fail++; $display("FAIL reset_instr_D got %h exp 0", bus.instr_D); end
    n_cmp++; if (bus.pc_plus4_D !== 32'h0) begin n_fail++; $display("FAIL reset_pc_plus4_D got %h exp 0", bus.pc_plus4_D); end
    n_cmp++; if ({bus.valid_D, bus.valid_E} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b exp 00", {bus.valid_D, bus.valid_E}); end
    n_cmp++; if (bus.ctrl_E !== 8'h0) begin n_fail++; $display("FAIL reset_ctrl_E got %h exp 0", bus.ctrl_E); end
    n_cmp++; if ({bus.rd1_E, bus.rd2_E, bus.sign_imm_E, bus.rs_E, bus.rt_E, bus.rd_E} !== '0) begin n_fail++; $display("FAIL reset_e_data got nonzero rd1_E %h", bus.rd1_E); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
    rst_n = 1'b1;
    idle_ctrl();
  endtask

  task automatic test_free_flow();
    for (int i = 0; i < 3; i++) begin
      pc_next_F = pc_tab[i]; instr_F = instr_tab[i]; pc_plus4_F = p4_tab[i];
      ctrl_D = ctrl_tab[i]; rd1_D = rd1_tab[i]; rd2_D = rd2_tab[i]; sign_imm_D = imm_tab[i];
      rs_D = rs_tab[i]; rt_D = rt_tab[i]; rd_D = rd_tab[i];
      step();
      n_cmp++; if (bus.pc_F !== pc_tab[i]) begin n_fail++; $display("FAIL flow_pc[%0d] got %h exp %h", i, bus.pc_F, pc_tab[i]); end
      n_cmp++; if ({bus.instr_D, bus.pc_plus4_D, bus.valid_D} !== {instr_tab[i], p4_tab[i], 1'b1}) begin n_fail++; $display("FAIL flow_ifid[%0d] got %h/%h/%b exp %h/%h/1", i, bus.instr_D, bus.pc_plus4_D, bus.valid_D, instr_tab[i], p4_tab[i]); end
      n_cmp++; if ({bus.ctrl_E, bus.rd1_E} !== {ctrl_tab[i], rd1_tab[i]}) begin n_fail++; $display("FAIL flow_ctrl_rd1_E[%0d] got %h/%h exp %h/%h", i, bus.ctrl_E, bus.rd1_E, ctrl_tab[i], rd1_tab[i]); end
      n_cmp++; if ({bus.rd2_E, bus.sign_imm_E, bus.rs_E, bus.rt_E, bus.rd_E} !== {rd2_tab[i], imm_tab[i], rs_tab[i], rt_tab[i], rd_tab[i]}) begin n_fail++; $display("FAIL flow_e_fields[%0d] got rd2 %h imm %h rs %0d rt %0d rd %0d", i, bus.rd2_E, bus.sign_imm_E, bus.rs_E, bus.rt_E, bus.rd_E); end
      n_cmp++; if (bus.valid_E !== (i > 0)) begin n_fail++; $display("FAIL flow_valid_E[%0d] got %b exp %b", i, bus.valid_E, (i > 0)); end
    end
  endtask

  task automatic test_load_use();
    stall_F = 1'b1; stall_D = 1'b1; flush_E = 1'b1;
    pc_next_F = 32'd16; instr_F = 32'hAC64_0000; pc_plus4_F = 32'h0000_0110;
    ctrl_D = 8'hFF; rd1_D = 32'hBAD0_BAD0;
    step();
    n_cmp++; if (bus.pc_F !== 32'd12) begin n_fail++; $display("FAIL lu_pc_hold got %h exp %h", bus.pc_F, 32'd12); end
    n_cmp++; if ({bus.instr_D, bus.pc_plus4_D, bus.valid_D} !== {32'h0043_1820, 32'h0000_010C, 1'b1}) begin n_fail++; $display("FAIL lu_ifid_hold got %h/%h/%b exp 00431820/0000010c/1", bus.instr_D, bus.pc_plus4_D, bus.valid_D); end
    n_cmp++; if ({bus.ctrl_E, bus.rd1_E, bus.valid_E} !== 41'h0) begin n_fail++; $display("FAIL lu_bubble got ctrl %h rd1 %h v %b exp 0", bus.ctrl_E, bus.rd1_E, bus.valid_E); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL lu_cnt got %0d/%0d exp 1/1", bus.stall_cnt, bus.flush_cnt); end
    idle_ctrl();
    ctrl_D = 8'h8C; rd1_D = 32'h0000_CAFE;
    step();
    n_cmp++; if ({bus.pc_F, bus.instr_D} !== {32'd16, 32'hAC64_0000}) begin n_fail++; $display("FAIL lu_resume_f got %h/%h exp 00000010/ac640000", bus.pc_F, bus.instr_D); end
    n_cmp++; if ({bus.ctrl_E, bus.rd1_E, bus.valid_E} !== {8'h8C, 32'h0000_CAFE, 1'b1}) begin n_fail++; $display("FAIL lu_reissue_E got %h/%h/%b exp 8c/0000cafe/1", bus.ctrl_E, bus.rd1_E, bus.valid_E); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL lu_cnt_after got %0d/%0d exp 1/1", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_stall_flush();
    stall_D = 1'b1; pc_next_F = 32'd20; instr_F = 32'h1234_5678; pc_plus4_F = 32'h0000_0114;
    step();
    n_cmp++; if ({bus.pc_F, bus.instr_D, bus.valid_D} !== {32'd20, 32'hAC64_0000, 1'b1}) begin n_fail++; $display("FAIL stallD_only got pc %h instr %h v %b", bus.pc_F, bus.instr_D, bus.valid_D); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL stallD_cnt got %0d/%0d exp 2/1", bus.stall_cnt, bus.flush_cnt); end
    flush_D = 1'b1; pc_next_F = 32'd24;
    step();
    n_cmp++; if ({bus.instr_D, bus.pc_plus4_D, bus.valid_D} !== 65'h0) begin n_fail++; $display("FAIL collide_ifid got %h/%h/%b exp 0/0/0", bus.instr_D, bus.pc_plus4_D, bus.valid_D); end
    n_cmp++; if ({bus.pc_F, bus.valid_E} !== {32'd24, 1'b1}) begin n_fail++; $display("FAIL collide_pc_vE got %h/%b exp 00000018/1", bus.pc_F, bus.valid_E); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== {16'd3, 16'd2}) begin n_fail++; $display("FAIL collide_cnt got %0d/%0d exp 3/2", bus.stall_cnt, bus.flush_cnt); end
    stall_D = 1'b0; flush_D = 1'b1; flush_E = 1'b1;
    step();
    n_cmp++; if ({bus.valid_D, bus.valid_E, bus.ctrl_E} !== 10'h0) begin n_fail++; $display("FAIL dual_flush_state got vD %b vE %b ctrl %h", bus.valid_D, bus.valid_E, bus.ctrl_E); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== {16'd3, 16'd3}) begin n_fail++; $display("FAIL dual_flush_cnt got %0d/%0d exp 3/3", bus.stall_cnt, bus.flush_cnt); end
    idle_ctrl();
    instr_F = 32'h0800_0010;
    step();
    n_cmp++; if ({bus.instr_D, bus.valid_D, bus.valid_E} !== {32'h0800_0010, 2'b10}) begin n_fail++; $display("FAIL after_flush got %h vD %b vE %b exp 08000010 1 0", bus.instr_D, bus.valid_D, bus.valid_E); end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; stall_D = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) begin
        n_cmp++; if (bus_s.stall_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_14 got %0d exp 14", bus_s.stall_cnt); end
      end
      if (k == 15) begin
        n_cmp++; if (bus_s.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_15 got %0d exp 15", bus_s.stall_cnt); end
      end
      if (k == 20) begin
        n_cmp++; if (bus_s.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", bus_s.stall_cnt); end
        n_cmp++; if (bus.stall_cnt !== 16'd20) begin n_fail++; $display("FAIL wide_cnt got %0d exp 20", bus.stall_cnt); end
        n_cmp++; if (bus_s.flush_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_flush got %0d exp 0", bus_s.flush_cnt); end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    stall_D = 1'b0; instr_F = 32'h3C01_1001; pc_plus4_F = 32'h0000_0204; ctrl_D = 8'hA5; rd1_D = 32'h0BAD_F00D;
    step();
    stall_D = 1'b1; stall_F = 1'b1; instr_F = 32'h2108_0001;
    step();
    n_cmp++; if ({bus.instr_D, bus.valid_D} !== {32'h3C01_1001, 1'b1}) begin n_fail++; $display("FAIL pre_rst_hold got %h/%b exp 3c011001/1", bus.instr_D, bus.valid_D); end
    rst_n = 1'b0;
    step();
    n_cmp++; if ({bus.pc_F, bus.instr_D, bus.pc_plus4_D, bus.valid_D} !== {RST_PC, 65'h0}) begin n_fail++; $display("FAIL midrst_f_d got pc %h instr %h p4 %h v %b", bus.pc_F, bus.instr_D, bus.pc_plus4_D, bus.valid_D); end
    n_cmp++; if ({bus.ctrl_E, bus.rd1_E, bus.valid_E} !== 41'h0) begin n_fail++; $display("FAIL midrst_e got ctrl %h rd1 %h v %b", bus.ctrl_E, bus.rd1_E, bus.valid_E); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt, bus_s.stall_cnt} !== 36'h0) begin n_fail++; $display("FAIL midrst_cnt got %0d/%0d/%0d exp 0/0/0", bus.stall_cnt, bus.flush_cnt, bus_s.stall_cnt); end
    rst_n = 1'b1;
    step();
    n_cmp++; if ({bus.pc_F, bus.instr_D, bus.valid_D} !== {RST_PC, 33'h0}) begin n_fail++; $display("FAIL post_rst_stall got pc %h instr %h v %b", bus.pc_F, bus.instr_D, bus.valid_D); end
    n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL post_rst_cnt got %0d exp 1", bus.stall_cnt); end
    idle_ctrl(); pc_next_F = 32'h0000_0040;
    step();
    n_cmp++; if ({bus.pc_F, bus.instr_D, bus.valid_D} !== {32'h0000_0040, 32'h2108_0001, 1'b1}) begin n_fail++; $display("FAIL resume_load got pc %h instr %h v %b", bus.pc_F, bus.instr_D, bus.valid_D); end
    n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL resume_cnt got %0d exp 1", bus.stall_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_ctrl();
    test_reset();
    test_free_flow();
    test_load_use();
    test_stall_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
